// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: datapath widths, default halt encoding,
// fetch FSM states and the next-PC source selector.
package cpu_pkg;

   localparam int INSTR_W = 16;
   localparam int ADDR_W  = 16;

   localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 16'hFFFF;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   typedef enum logic [2:0] {
      PC_HOLD   = 3'd0,
      PC_SEQ    = 3'd1,
      PC_JUMP   = 3'd2,
      PC_BRANCH = 3'd3,
      PC_RESET  = 3'd4
   } pc_sel_t;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: hold, sequential +2, absolute jump,
// PC-relative branch from the fetched instruction's address, or restart.
module pc_next_logic
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] instr_pc,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [7:0]        branch_offset,
   input  pc_sel_t           sel,
   output logic [ADDR_W-1:0] pc_next
);

   logic [ADDR_W-1:0] branch_disp_s;

   // Word offset sign-extended and scaled to bytes; the add wraps modulo 2^16.
   assign branch_disp_s = {{7{branch_offset[7]}}, branch_offset, 1'b0};

   // Next-PC multiplexer
   always_comb begin
      pc_next = pc;
      case (sel)
         PC_HOLD:   pc_next = pc;
         PC_SEQ:    pc_next = pc + 16'd2;
         PC_JUMP:   pc_next = jump_target & 16'hFFFE;
         PC_BRANCH: pc_next = instr_pc + 16'd2 + branch_disp_s;
         PC_RESET:  pc_next = RESET_PC & 16'hFFFE;
         default:   pc_next = pc;
      endcase
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, presents it to the instruction memory and captures
// the returned word into the decode-facing fetch register, with RUN/HALT control.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
   parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stall,
   input  logic               jump,
   input  logic [ADDR_W-1:0]  jump_target,
   input  logic               branch_taken,
   input  logic [7:0]         branch_offset,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   output logic               halted
);

   fetch_state_t       state_r;
   fetch_state_t       state_next_s;
   logic [ADDR_W-1:0]  pc_r;
   logic [ADDR_W-1:0]  pc_next_s;
   logic [INSTR_W-1:0] instr_r;
   logic [ADDR_W-1:0]  instr_pc_r;
   logic               instr_valid_r;
   pc_sel_t            pc_sel_s;
   logic               capture_s;
   logic               valid_next_s;
   logic               halt_seen_s;

   // A captured halt word, presented for its one valid cycle, retires fetch on the next edge.
   assign halt_seen_s = instr_valid_r && (instr_r == HALT_WORD);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= HALT;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         HALT: begin
            if (start) begin
               state_next_s = RUN;
            end else begin
               state_next_s = HALT;
            end
         end
         RUN: begin
            if (start) begin
               state_next_s = RUN;
            end else if (halt_seen_s) begin
               state_next_s = HALT;
            end else begin
               state_next_s = RUN;
            end
         end
         default: state_next_s = HALT;
      endcase
   end

   // FSM outputs: PC source, fetch capture and validity; redirects act only on a valid instruction
   always_comb begin
      pc_sel_s     = PC_HOLD;
      capture_s    = 1'b0;
      valid_next_s = instr_valid_r;
      case (state_r)
         HALT: begin
            valid_next_s = 1'b0;
            if (start) begin
               pc_sel_s = PC_RESET;
            end else begin
               pc_sel_s = PC_HOLD;
            end
         end
         RUN: begin
            if (start) begin
               pc_sel_s     = PC_RESET;
               valid_next_s = 1'b0;
            end else if (halt_seen_s) begin
               pc_sel_s     = PC_HOLD;
               valid_next_s = 1'b0;
            end else if (jump && instr_valid_r) begin
               pc_sel_s     = PC_JUMP;
               valid_next_s = 1'b0;
            end else if (branch_taken && instr_valid_r) begin
               pc_sel_s     = PC_BRANCH;
               valid_next_s = 1'b0;
            end else if (stall) begin
               pc_sel_s     = PC_HOLD;
               valid_next_s = instr_valid_r;
            end else begin
               pc_sel_s     = PC_SEQ;
               capture_s    = 1'b1;
               valid_next_s = 1'b1;
            end
         end
         default: begin
            pc_sel_s     = PC_HOLD;
            valid_next_s = 1'b0;
         end
      endcase
   end

   pc_next_logic #(
      .RESET_PC (RESET_PC)
   ) u_pc_next (
      .pc            (pc_r),
      .instr_pc      (instr_pc_r),
      .jump_target   (jump_target),
      .branch_offset (branch_offset),
      .sel           (pc_sel_s),
      .pc_next       (pc_next_s)
   );

   // PC and fetch register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r          <= RESET_PC & 16'hFFFE;
         instr_r       <= 16'h0000;
         instr_pc_r    <= 16'h0000;
         instr_valid_r <= 1'b0;
      end else begin
         pc_r          <= pc_next_s;
         instr_valid_r <= valid_next_s;
         if (capture_s) begin
            instr_r    <= imem_rdata;
            instr_pc_r <= pc_r;
         end else begin
            instr_r    <= instr_r;
            instr_pc_r <= instr_pc_r;
         end
      end
   end

   assign imem_addr   = pc_r;
   assign instr       = instr_r;
   assign instr_pc    = instr_pc_r;
   assign instr_valid = instr_valid_r;
   assign halted      = (state_r == HALT);

endmodule
